// File: rtl/decrypt_msg_scanner.sv
// Walks the decrypted message through the decrypted-RAM interface: verify mode checks
// every byte is [a-z] or space, clear mode overwrites the region with FILL_BYTE.
module decrypt_msg_scanner #(
  parameter int          MSG_LEN   = 32,
  parameter logic [7:0]  BASE_ADR  = 8'h00,
  parameter logic [7:0]  FILL_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       op,
  output logic       busy,
  output logic       done,
  output logic       msg_ok,
  output logic [7:0] fail_index,
  output logic       mem_start,
  output logic       mem_readWrite,
  output logic [7:0] mem_adr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_finish
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;

  localparam logic [7:0] LAST = 8'(MSG_LEN - 1);

  state_t     state, state_nxt;
  logic [7:0] idx, byte_reg;
  logic       legal, last;

  assign legal     = (byte_reg == 8'h20) || (byte_reg >= 8'h61 && byte_reg <= 8'h7A);
  assign last      = (idx == LAST);
  assign mem_wdata = FILL_BYTE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // mem_readWrite doubles as the latched op for the whole pass
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (mem_finish) begin
               if (!mem_readWrite) state_nxt = CHECK;
               else                state_nxt = last ? DONE : ISSUE;
             end
      CHECK: state_nxt = (!legal || last) ? DONE : ISSUE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_start = 1'b0;
    case (state)
      IDLE:    ;
      ISSUE:   begin busy = 1'b1; mem_start = 1'b1; end
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: busy = 1'b1;
    endcase
  end

  // address is set up one edge ahead of ISSUE so it is stable for the whole request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx           <= 8'h00;
      byte_reg      <= 8'h00;
      mem_adr       <= 8'h00;
      mem_readWrite <= 1'b0;
      msg_ok        <= 1'b0;
      fail_index    <= 8'h00;
    end else begin
      case (state)
        IDLE: if (start) begin
          mem_readWrite <= op;
          idx           <= 8'h00;
          msg_ok        <= 1'b0;
          fail_index    <= 8'h00;
          mem_adr       <= BASE_ADR;
        end
        WAIT: if (mem_finish) begin
          if (!mem_readWrite) byte_reg <= mem_rdata;
          else if (!last) begin
            idx     <= idx + 8'd1;
            mem_adr <= BASE_ADR + idx + 8'd1;
          end
        end
        CHECK: begin
          if (!legal)    fail_index <= idx;
          else if (last) msg_ok     <= 1'b1;
          else begin
            idx     <= idx + 8'd1;
            mem_adr <= BASE_ADR + idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decrypt_msg_scanner.sv
// Randomized bench: a behavioural RAM/interface responder plus a pass-level model of
// expected request count, addresses, done cycle and verdict.
module tb_decrypt_msg_scanner;

  localparam int         MSG_LEN = 32;
  localparam logic [7:0] BASE    = 8'hF0;
  localparam logic [7:0] FILL    = 8'h00;

  logic       clk = 1'b0;
  logic       reset_n, start, op;
  logic       busy, done, msg_ok, mem_start, mem_readWrite, mem_finish;
  logic [7:0] fail_index, mem_adr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [256];
  logic [7:0] msg [MSG_LEN];

  always #5 clk = ~clk;

  decrypt_msg_scanner #(.MSG_LEN(MSG_LEN), .BASE_ADR(BASE), .FILL_BYTE(FILL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .busy(busy), .done(done), .msg_ok(msg_ok), .fail_index(fail_index),
    .mem_start(mem_start), .mem_readWrite(mem_readWrite), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_finish(mem_finish)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [7:0] c);
    return (c == 8'h20) || (c >= 8'h61 && c <= 8'h7A);
  endfunction

  function automatic logic [7:0] rand_legal();
    int r;
    r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  function automatic logic [7:0] rand_illegal();
    logic [7:0] c;
    c = 8'($urandom);
    while (is_legal(c)) c = 8'($urandom);
    return c;
  endfunction

  task automatic fill_legal();
    for (int i = 0; i < MSG_LEN; i++) msg[i] = rand_legal();
  endtask

  // One pass: start at cycle 0, optional stray start at pulse_at, optional reset at rst_at.
  task automatic run_pass(input bit o, input int pulse_at, input int rst_at);
    int k, exp_req, exp_done, exp_fi, cyc, pend, nreq, ndone, done_cyc;
    int bad_adr, bad_rw, bad_wd, viol, idle_busy, bad_ram, rst_bad;
    bit exp_ok, cur_rw;
    logic [7:0] cur_adr, cur_wd;

    k = -1;
    if (!o)
      for (int i = MSG_LEN - 1; i >= 0; i--) if (!is_legal(msg[i])) k = i;
    exp_req  = (!o && k >= 0) ? k + 1 : MSG_LEN;
    exp_done = 1 + (o ? 5 : 6) * exp_req;
    exp_ok   = !o && (k < 0);
    exp_fi   = (!o && k >= 0) ? k : 0;
    for (int i = 0; i < MSG_LEN; i++)
      ram[8'(BASE + i)] = o ? 8'($urandom_range(1, 255)) : msg[i];

    pend = 0; nreq = 0; ndone = 0; done_cyc = -1;
    bad_adr = 0; bad_rw = 0; bad_wd = 0; viol = 0; idle_busy = 0; rst_bad = 0;
    cur_adr = 8'h00; cur_wd = 8'h00; cur_rw = 1'b0;

    @(negedge clk); start = 1'b1; op = o;
    @(negedge clk); start = 1'b0; op = 1'($urandom);
    cyc = 1;
    while (cyc <= 1 + 6 * MSG_LEN + 8) begin
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("post_done_pulse", done, 0);
        chk("post_done_busy", busy, 0);
        chk("hold_msg_ok", msg_ok, exp_ok);
        chk("hold_fail_index", fail_index, exp_fi);
        break;
      end
      if (cyc == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_mem_start", mem_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state_vals", {msg_ok, fail_index, mem_adr, mem_readWrite}, 0);
        mem_finish = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (done || busy || mem_start) rst_bad++;
        end
        chk("rst_no_activity", rst_bad, 0);
        reset_n = 1'b1;
        return;
      end
      // memory interface: finish 4 cycles after the request cycle
      if (mem_start && pend != 0) viol++;
      mem_finish = 1'b0;
      mem_rdata  = 8'($urandom);
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_finish = 1'b1;
          if (cur_rw) ram[cur_adr] = cur_wd;
          else        mem_rdata = ram[cur_adr];
        end
      end
      if (mem_start) begin
        if (mem_adr !== 8'(BASE + nreq)) bad_adr++;
        if (mem_readWrite !== o) bad_rw++;
        if (o && mem_wdata !== FILL) bad_wd++;
        cur_adr = mem_adr; cur_rw = mem_readWrite; cur_wd = mem_wdata;
        pend = 4;
        nreq++;
      end
      if (!busy && done_cyc < 0) idle_busy++;
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          chk("msg_ok", msg_ok, exp_ok);
          chk("fail_index", fail_index, exp_fi);
        end
      end
      start = (cyc == pulse_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    mem_finish = 1'b0;

    bad_ram = 0;
    if (o) for (int i = 0; i < MSG_LEN; i++) if (ram[8'(BASE + i)] !== FILL) bad_ram++;
    chk("done_cycle", done_cyc, exp_done);
    chk("num_requests", nreq, exp_req);
    chk("addr_seq_errs", bad_adr, 0);
    chk("rw_errs", bad_rw, 0);
    chk("wdata_errs", bad_wd, 0);
    chk("outstanding_viol", viol, 0);
    chk("busy_drop", idle_busy, 0);
    chk("done_pulses", ndone, 1);
    chk("ram_fill_errs", bad_ram, 0);
  endtask

  initial begin
    int rbad;
    logic [7:0] bvals [6];
    bvals[0] = 8'h20; bvals[1] = 8'h61; bvals[2] = 8'h7A;
    bvals[3] = 8'h1F; bvals[4] = 8'h60; bvals[5] = 8'h7B;

    reset_n = 1'b0; start = 1'b1; op = 1'b1; mem_finish = 1'b0; mem_rdata = 8'h00;
    rbad = 0;
    repeat (6) begin
      @(negedge clk);
      mem_finish = ~mem_finish;
      if (mem_start || busy || done) rbad++;
    end
    chk("reset_activity", rbad, 0);
    chk("reset_msg_ok", msg_ok, 0);
    chk("reset_fail_index", fail_index, 0);
    chk("reset_mem_adr", mem_adr, 0);
    chk("reset_mem_rw", mem_readWrite, 0);
    chk("reset_mem_wdata", mem_wdata, FILL);
    @(negedge clk); start = 1'b0; mem_finish = 1'b0; reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < MSG_LEN; i++) msg[i] = 8'h61;
    run_pass(1'b0, -1, -1);

    fill_legal(); msg[5] = 8'h41;
    run_pass(1'b0, -1, -1);

    for (int b = 0; b < 6; b++) begin
      fill_legal(); msg[0] = bvals[b];
      run_pass(1'b0, -1, -1);
    end

    run_pass(1'b1, 50, -1);
    fill_legal();
    run_pass(1'b0, 50, -1);

    fill_legal();
    run_pass(1'b0, -1, 20);
    fill_legal();
    run_pass(1'b0, -1, -1);

    for (int t = 0; t < 8; t++) begin
      fill_legal();
      if ($urandom_range(0, 1)) msg[$urandom_range(0, MSG_LEN - 1)] = rand_illegal();
      run_pass(1'($urandom), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
